// File: rtl/text_console_if.sv
`default_nettype none
// ============================================================================
//  Module      : text_console_if
//  Description : Host character stream port for text_console. The host
//                drives a 7-bit code with a valid strobe; the console
//                answers with ready. A code transfers on any clock edge
//                where valid and ready are both high.
//  Signals     : char_i       [6:0] host character/control code
//                char_valid_i       char_i valid
//                char_ready_o       console can accept char_i this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
interface text_console_if;
    logic [6:0] char_i;
    logic       char_valid_i;
    logic       char_ready_o;

    modport master (
        output char_i,
        output char_valid_i,
        input  char_ready_o
    );

    modport slave (
        input  char_i,
        input  char_valid_i,
        output char_ready_o
    );
endinterface
`default_nettype wire

// File: rtl/text_console.sv
`default_nettype none
// ============================================================================
//  Module      : text_console
//  Description : Character-cell text buffer (one 7-bit code per 8x8 cell)
//                with a host write FSM and a 2-stage scan address pipeline
//                feeding the glyph generator.
//  Ports       : clk_i, rstn_i          pixel clock, async active-low reset
//                host (slave modport)    char_i / char_valid_i / char_ready_o
//                x_i, y_i               pixel coordinates from VGA timing
//                de_i, hsync_i, vsync_i display enable and syncs in
//                chr_ord_o              character code for current cell
//                cell_col_o, cell_lin_o pixel position inside the cell
//                de_o, hsync_o, vsync_o syncs aligned with chr_ord_o
//                cursor_col_o/row_o     hardware cursor position
//  Revision    : 1.0 - initial release
// ============================================================================
module text_console #(
    parameter int         COLS      = 80,
    parameter int         ROWS      = 60,
    parameter logic [6:0] BLANK_CHR = 7'h20
) (
    input  wire         clk_i,
    input  wire         rstn_i,
    text_console_if.slave host,
    input  wire  [9:0]  x_i,
    input  wire  [9:0]  y_i,
    input  wire         de_i,
    input  wire         hsync_i,
    input  wire         vsync_i,
    output logic [6:0]  chr_ord_o,
    output logic [2:0]  cell_col_o,
    output logic [2:0]  cell_lin_o,
    output logic        de_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic [6:0]  cursor_col_o,
    output logic [5:0]  cursor_row_o
);

    localparam int c_cells = COLS * ROWS;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    // row*COLS + col; the default geometry uses the shift/add form so no
    // multiplier is needed on either port.
    function automatic logic [12:0] cell_addr(input logic [6:0] row,
                                              input logic [6:0] col);
        if (COLS == 80)
            return (13'(row) << 6) + (13'(row) << 4) + 13'(col);
        else
            return 13'(int'(row) * COLS + int'(col));
    endfunction

    // ------------------------------------------------------------------
    // Character buffer
    // ------------------------------------------------------------------
    logic [6:0] mem [0:c_cells-1];

    logic       w_we;
    logic [12:0] w_waddr;
    logic [6:0] w_wdata;

    always_ff @(posedge clk_i) begin
        if (w_we)
            mem[w_waddr] <= w_wdata;
    end

    // ------------------------------------------------------------------
    // Host FSM
    // ------------------------------------------------------------------
    state_t      r_state, w_state_nxt;
    logic [12:0] r_clr_addr, w_clr_addr_nxt;
    logic [6:0]  r_col, w_col_nxt;
    logic [5:0]  r_row, w_row_nxt;
    logic [5:0]  w_row_inc;
    logic        w_xfer;
    logic        w_printable;

    assign w_row_inc   = (r_row == 6'(ROWS - 1)) ? 6'd0 : r_row + 6'd1;
    assign w_xfer      = host.char_valid_i && (r_state == ST_IDLE);
    assign w_printable = (host.char_i >= 7'h20) && (host.char_i <= 7'h7E);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= 13'd0;
            r_col      <= 7'd0;
            r_row      <= 6'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
            r_col      <= w_col_nxt;
            r_row      <= w_row_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        w_col_nxt      = r_col;
        w_row_nxt      = r_row;
        w_we           = 1'b0;
        w_waddr        = cell_addr({1'b0, r_row}, r_col);
        w_wdata        = host.char_i;

        case (r_state)
            ST_CLEAR: begin
                w_we    = 1'b1;
                w_waddr = r_clr_addr;
                w_wdata = BLANK_CHR;
                if (r_clr_addr == 13'(c_cells - 1)) begin
                    w_state_nxt    = ST_IDLE;
                    w_clr_addr_nxt = 13'd0;
                    w_col_nxt      = 7'd0;
                    w_row_nxt      = 6'd0;
                end else begin
                    w_clr_addr_nxt = r_clr_addr + 13'd1;
                end
            end
            default: begin
                if (w_xfer) begin
                    if (w_printable) begin
                        w_we = 1'b1;
                        if (r_col == 7'(COLS - 1)) begin
                            w_col_nxt = 7'd0;
                            w_row_nxt = w_row_inc;
                        end else begin
                            w_col_nxt = r_col + 7'd1;
                        end
                    end else begin
                        case (host.char_i)
                            7'h0D: w_col_nxt = 7'd0;
                            7'h0A: w_row_nxt = w_row_inc;
                            7'h08: if (r_col != 7'd0) w_col_nxt = r_col - 7'd1;
                            7'h0C: begin
                                w_state_nxt    = ST_CLEAR;
                                w_clr_addr_nxt = 13'd0;
                            end
                            default: ; // other control codes are swallowed
                        endcase
                    end
                end
            end
        endcase
    end

    assign host.char_ready_o = (r_state == ST_IDLE);
    assign cursor_col_o      = r_col;
    assign cursor_row_o      = r_row;

    // ------------------------------------------------------------------
    // Scan pipeline: stage 1 forms the cell address, stage 2 holds the
    // RAM read data; the companions travel alongside.
    // ------------------------------------------------------------------
    logic [12:0] r_s1_addr;
    logic [2:0]  r_s1_cx, r_s1_cy, r_s2_cx, r_s2_cy;
    logic        r_s1_de, r_s1_hs, r_s1_vs;
    logic        r_s2_de, r_s2_hs, r_s2_vs;
    logic [6:0]  r_s2_data;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_s1_addr <= 13'd0;
            r_s1_cx   <= 3'd0;
            r_s1_cy   <= 3'd0;
            r_s1_de   <= 1'b0;
            r_s1_hs   <= 1'b0;
            r_s1_vs   <= 1'b0;
            r_s2_cx   <= 3'd0;
            r_s2_cy   <= 3'd0;
            r_s2_de   <= 1'b0;
            r_s2_hs   <= 1'b0;
            r_s2_vs   <= 1'b0;
        end else begin
            r_s1_addr <= cell_addr(y_i[9:3], x_i[9:3]);
            r_s1_cx   <= x_i[2:0];
            r_s1_cy   <= y_i[2:0];
            r_s1_de   <= de_i;
            r_s1_hs   <= hsync_i;
            r_s1_vs   <= vsync_i;
            r_s2_cx   <= r_s1_cx;
            r_s2_cy   <= r_s1_cy;
            r_s2_de   <= r_s1_de;
            r_s2_hs   <= r_s1_hs;
            r_s2_vs   <= r_s1_vs;
        end
    end

    // RAM output register kept reset-free so it maps onto block RAM; its
    // value is hidden behind the delayed display enable, which is reset.
    always_ff @(posedge clk_i) begin
        r_s2_data <= mem[r_s1_addr];
    end

    assign chr_ord_o  = r_s2_de ? r_s2_data : BLANK_CHR;
    assign cell_col_o = r_s2_cx;
    assign cell_lin_o = r_s2_cy;
    assign de_o       = r_s2_de;
    assign hsync_o    = r_s2_hs;
    assign vsync_o    = r_s2_vs;

endmodule
`default_nettype wire

// File: tb/tb_text_console.sv
`default_nettype none
// ============================================================================
//  Module      : tb_text_console
//  Description : Self-checking bench for text_console: cursor vector table,
//                full-frame scans against a buffer model, clear timing,
//                mid-clear reset and scan pipeline delay.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_text_console;
    localparam int         COLS  = 80;
    localparam int         ROWS  = 60;
    localparam int         CELLS = COLS * ROWS;
    localparam int         LIMIT = 10000;
    localparam logic [6:0] BLANK = 7'h20;

    logic       clk = 1'b0;
    logic       rstn;
    logic [9:0] x, y;
    logic       de, hs, vs;
    logic [6:0] chr_ord;
    logic [2:0] cell_col, cell_lin;
    logic       de_o, hs_o, vs_o;
    logic [6:0] cur_col;
    logic [5:0] cur_row;

    text_console_if hif ();

    text_console dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .host         (hif.slave),
        .x_i          (x),
        .y_i          (y),
        .de_i         (de),
        .hsync_i      (hs),
        .vsync_i      (vs),
        .chr_ord_o    (chr_ord),
        .cell_col_o   (cell_col),
        .cell_lin_o   (cell_lin),
        .de_o         (de_o),
        .hsync_o      (hs_o),
        .vsync_o      (vs_o),
        .cursor_col_o (cur_col),
        .cursor_row_o (cur_row)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [6:0] exp_mem [0:CELLS-1];
    int m_col, m_row;

    typedef struct {
        logic [6:0] code;
        int         col;
        int         row;
    } vec_t;
    vec_t vecs [13];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_apply(input logic [6:0] c);
        if (c >= 7'h20 && c <= 7'h7E) begin
            exp_mem[m_row * COLS + m_col] = c;
            if (m_col == COLS - 1) begin
                m_col = 0;
                m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
            end else begin
                m_col++;
            end
        end else begin
            case (c)
                7'h0D: m_col = 0;
                7'h0A: m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
                7'h08: if (m_col > 0) m_col--;
                7'h0C: begin
                    for (int k = 0; k < CELLS; k++) exp_mem[k] = BLANK;
                    m_col = 0;
                    m_row = 0;
                end
                default: ;
            endcase
        end
    endfunction

    // Entered and left just after a falling edge.
    task automatic send(input logic [6:0] c);
        int n = 0;
        while (!hif.char_ready_o && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) check("send_ready_timeout", 0, 1);
        hif.char_i       = c;
        hif.char_valid_i = 1'b1;
        @(negedge clk);
        hif.char_valid_i = 1'b0;
        model_apply(c);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!hif.char_ready_o && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_cursor(input string name, input int col, input int row);
        check(name, {16'(cur_row), 16'(cur_col)}, {16'(row), 16'(col)});
    endtask

    task automatic scan_point(input int px, input int py, input logic pde,
                              output int packed_out);
        x  = 10'(px);
        y  = 10'(py);
        de = pde;
        @(negedge clk);
        @(negedge clk);
        packed_out = {chr_ord, 1'b0, cell_col, 1'b0, cell_lin};
        de = 1'b0;
    endtask

    function automatic int pk(input int c, input int cc, input int cl);
        return (c << 8) | (cc << 4) | cl;
    endfunction

    task automatic frame_check(input string name);
        int bad = 0;
        int first = -1;
        int got_f = 0, exp_f = 0;
        for (int i = 0; i < CELLS + 2; i++) begin
            if (i >= 2) begin
                int k = i - 2;
                int e = pk(int'(exp_mem[k]), k % 8, (k / 8) % 8);
                int g = pk(int'(chr_ord), int'(cell_col), int'(cell_lin));
                if (g != e || !de_o) begin
                    bad++;
                    if (first < 0) begin
                        first = k;
                        got_f = g;
                        exp_f = e;
                    end
                end
            end
            if (i < CELLS) begin
                x  = 10'((i % COLS) * 8 + i % 8);
                y  = 10'((i / COLS) * 8 + (i / 8) % 8);
                de = 1'b1;
            end else begin
                de = 1'b0;
            end
            @(negedge clk);
        end
        de = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d bad cells, first cell %0d got 0x%0h expected 0x%0h",
                     name, bad, first, got_f, exp_f);
        end
    endtask

    task automatic check_delay(input string name, input int cycles);
        logic [2:0] hist [$];
        for (int i = 0; i < cycles; i++) begin
            logic [2:0] s;
            if (i >= 2) check(name, {de_o, hs_o, vs_o}, hist[i - 2]);
            s  = 3'($urandom_range(0, 7));
            de = s[2];
            hs = s[1];
            vs = s[0];
            hist.push_back(s);
            @(negedge clk);
        end
        de = 1'b0;
        hs = 1'b0;
        vs = 1'b0;
    endtask

    initial begin
        int n;
        int p;

        rstn = 1'b0;
        x = '0; y = '0; de = 1'b0; hs = 1'b0; vs = 1'b0;
        hif.char_i = '0;
        hif.char_valid_i = 1'b0;
        m_col = 0;
        m_row = 0;
        for (int k = 0; k < CELLS; k++) exp_mem[k] = BLANK;

        vecs[0]  = '{7'h0D, 0, 0};
        vecs[1]  = '{7'h08, 0, 0};
        vecs[2]  = '{7'h0A, 0, 1};
        vecs[3]  = '{7'h68, 1, 1};
        vecs[4]  = '{7'h07, 1, 1};
        vecs[5]  = '{7'h08, 0, 1};
        vecs[6]  = '{7'h7E, 1, 1};
        vecs[7]  = '{7'h1F, 1, 1};
        vecs[8]  = '{7'h7F, 1, 1};
        vecs[9]  = '{7'h0A, 1, 2};
        vecs[10] = '{7'h0A, 1, 3};
        vecs[11] = '{7'h0A, 1, 4};
        vecs[12] = '{7'h0A, 1, 5};

        // Reset values while held
        repeat (3) @(negedge clk);
        check("rst_ready", int'(hif.char_ready_o), 0);
        check_cursor("rst_cursor", 0, 0);
        check("rst_scan", pk(int'(chr_ord), int'(cell_col), int'(cell_lin)), pk(32'h20, 0, 0));
        check("rst_syncs", {de_o, hs_o, vs_o}, 0);

        // Reset release: blanking clear length
        rstn = 1'b1;
        wait_ready(n);
        check("rst_clear_len", n, CELLS);
        check_cursor("rst_cursor_after_clear", 0, 0);
        frame_check("frame_after_reset");

        // "AB" back-to-back
        hif.char_i = 7'h41;
        hif.char_valid_i = 1'b1;
        @(negedge clk);
        hif.char_i = 7'h42;
        @(negedge clk);
        hif.char_valid_i = 1'b0;
        model_apply(7'h41);
        model_apply(7'h42);
        check_cursor("ab_cursor", 2, 0);
        scan_point(3, 2, 1'b0, p);
        check("de_low_blank", p, pk(32'h20, 3, 2));
        scan_point(3, 2, 1'b1, p);
        check("cell_0_0", p, pk(32'h41, 3, 2));
        for (int i = 0; i < 66; i++) begin
            if (i >= 2) check("ab_scan", pk(int'(chr_ord), int'(cell_col), int'(cell_lin)),
                              pk(32'h42, (i - 2) % 8, (i - 2) / 8));
            if (i < 64) begin
                x = 10'(8 + i % 8);
                y = 10'(i / 8);
                de = 1'b1;
            end else begin
                de = 1'b0;
            end
            @(negedge clk);
        end
        de = 1'b0;

        // Cursor vector table
        for (int i = 0; i < 13; i++) begin
            send(vecs[i].code);
            check_cursor($sformatf("vec%0d_cursor", i), vecs[i].col, vecs[i].row);
        end

        // Line wrap at the last column
        for (int i = 0; i < 78; i++) send(7'(97 + i % 26));
        check_cursor("col79_cursor", 79, 5);
        send(7'h5A);
        check_cursor("wrap_cursor", 0, 6);
        scan_point(79 * 8 + 3, 5 * 8 + 2, 1'b1, p);
        check("cell_79_5", p, pk(32'h5A, 3, 2));

        // Row wrap on LF at the last row, then CR
        for (int i = 0; i < 53; i++) send(7'h0A);
        for (int i = 0; i < 3; i++) send(7'(120 + i));
        check_cursor("row59_cursor", 3, 59);
        send(7'h0A);
        check_cursor("lf_wrap_cursor", 3, 0);
        send(7'h0D);
        check_cursor("cr_cursor", 0, 0);

        // Backspace inside a line leaves the cell alone
        for (int i = 0; i < 10; i++) send(7'(48 + i));
        check_cursor("col10_cursor", 10, 0);
        send(7'h08);
        check_cursor("bs_cursor", 9, 0);
        scan_point(9 * 8 + 7, 7, 1'b1, p);
        check("bs_cell_kept", p, pk(32'h39, 7, 7));
        frame_check("frame_after_text");

        // Form feed with valid held high through the clear
        hif.char_i = 7'h0C;
        hif.char_valid_i = 1'b1;
        @(negedge clk);
        model_apply(7'h0C);
        hif.char_i = 7'h58;
        check("ff_ready_low", int'(hif.char_ready_o), 0);
        wait_ready(n);
        hif.char_valid_i = 1'b0;
        check("ff_clear_len", n, CELLS);
        check_cursor("ff_cursor", 0, 0);
        frame_check("frame_after_ff");

        // Reset in the middle of a clear
        send(7'h48);
        send(7'h69);
        send(7'h0C);
        check_delay("sync_delay", 30);
        repeat (1000 - 30) @(negedge clk);
        x = 10'd7; y = 10'd7; de = 1'b1; hs = 1'b1; vs = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_syncs", {de_o, hs_o, vs_o, cell_col, cell_lin}, 9'h1FF);
        rstn = 1'b0;
        #1;
        check("midrst_ready", int'(hif.char_ready_o), 0);
        check_cursor("midrst_cursor", 0, 0);
        check("midrst_scan", pk(int'(chr_ord), int'(cell_col), int'(cell_lin)), pk(32'h20, 0, 0));
        check("midrst_syncs", {de_o, hs_o, vs_o}, 0);
        x = '0; y = '0; de = 1'b0; hs = 1'b0; vs = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        wait_ready(n);
        check("midrst_clear_len", n, CELLS);
        check_cursor("midrst_cursor_after", 0, 0);
        check_delay("sync_delay_post", 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
